// File: rtl/pipe_pkg.sv
// Shared types for the pipeline-stage registers: skid FSM states, default
// stall-counter width and the packed payloads carried between CPU stages.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_INIT  = 2'd0,
        PS_EMPTY = 2'd1,
        PS_HALF  = 2'd2,
        PS_FULL  = 2'd3
    } ps_state_t;

    localparam int PIPE_CNT_W = 16;

    // Packed stage payloads; $bits() of each one sets DATA_W at its stage.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } idex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } exmem_t;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Width-parameterised saturating up-counter with an asynchronous active-high reset.
module pipe_sat_cnt
    import pipe_pkg::*;
#(
    parameter int W = PIPE_CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer and registered in_ready_o.
// Define PIPE_STAGE_STALL_CNT_EN to build the saturating back-pressure counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W         = 32,
    parameter logic [DATA_W-1:0] RESET_VAL      = '0,
    parameter bit                CLEAR_ON_FLUSH = 1'b1,
    parameter int                CNT_W          = PIPE_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    ps_state_t         state_q;
    logic              in_ready_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_fire;
    logic              out_fire;

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q == PS_HALF) || (state_q == PS_FULL);
    assign out_data_o  = main_q;
    assign in_fire     = in_valid_i & in_ready_q;
    assign out_fire    = out_valid_o & out_ready_i;

    // in_ready_q is set alongside every state change so it always mirrors EMPTY/HALF.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= PS_INIT;
            in_ready_q <= 1'b0;
            main_q     <= RESET_VAL;
            skid_q     <= RESET_VAL;
        end else if (flush_i) begin
            // The post-reset hold-off survives a flush; otherwise drop everything.
            if (state_q == PS_INIT) begin
                state_q    <= PS_INIT;
                in_ready_q <= 1'b0;
            end else begin
                state_q    <= PS_EMPTY;
                in_ready_q <= 1'b1;
            end
            if (CLEAR_ON_FLUSH) begin
                main_q <= RESET_VAL;
                skid_q <= RESET_VAL;
            end
        end else begin
            case (state_q)
                PS_INIT: begin
                    state_q    <= PS_EMPTY;
                    in_ready_q <= 1'b1;
                end
                PS_EMPTY: begin
                    if (in_fire) begin
                        main_q  <= in_data_i;
                        state_q <= PS_HALF;
                    end
                end
                PS_HALF: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data_i;
                    end else if (in_fire) begin
                        skid_q     <= in_data_i;
                        state_q    <= PS_FULL;
                        in_ready_q <= 1'b0;
                    end else if (out_fire) begin
                        state_q <= PS_EMPTY;
                    end
                end
                PS_FULL: begin
                    if (out_fire) begin
                        main_q     <= skid_q;
                        state_q    <= PS_HALF;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= PS_INIT;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic stall_inc;

    assign stall_inc = out_valid_o & ~out_ready_i;

    pipe_sat_cnt #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .inc_i(stall_inc),
        .cnt_o(stall_cnt_o)
    );
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: queue-based occupancy model checked every cycle,
// plus directed literal checks of reset, streaming, skid, flush and stall count.
module tb_pipe_stage_skid;

    localparam int DW = 8;
    localparam int CW = 2;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          flush_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b1;
    logic [DW-1:0] out_data_o;
    logic [CW-1:0] stall_cnt_o;

    int total = 0;
    int bad   = 0;

    pipe_stage_skid #(
        .DATA_W(DW),
        .RESET_VAL(8'h00),
        .CLEAR_ON_FLUSH(1'b1),
        .CNT_W(CW)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .flush_i(flush_i),
        .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o),
        .in_data_i(in_data_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o(out_data_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Model: a FIFO of at most two payloads, a hold-off flag, a registered ready.
    logic [DW-1:0] m_q[$];
    bit            m_init = 1'b1;
    bit            m_rdy  = 1'b0;
    int            m_cnt  = 0;

    always @(posedge clk_i or posedge rst_i) begin
        bit ifire;
        bit ofire;
        if (rst_i) begin
            m_q.delete();
            m_init = 1'b1;
            m_rdy  = 1'b0;
            m_cnt  = 0;
        end else begin
            ifire = in_valid_i && m_rdy;
            ofire = (m_q.size() > 0) && out_ready_i;
`ifdef PIPE_STAGE_STALL_CNT_EN
            if ((m_q.size() > 0) && !out_ready_i && (m_cnt < (1 << CW) - 1))
                m_cnt = m_cnt + 1;
`endif
            if (flush_i) begin
                m_q.delete();
            end else if (m_init) begin
                m_init = 1'b0;
            end else begin
                if (ofire) void'(m_q.pop_front());
                if (ifire) m_q.push_back(in_data_i);
            end
            m_rdy = !m_init && (m_q.size() < 2);
        end
    end

    // Every-cycle comparison against the model, plus a log of delivered payloads.
    logic [DW-1:0] got[$];

    always @(negedge clk_i) begin
        if (!rst_i) begin
            chk("model_out_valid", 32'(out_valid_o), 32'(m_q.size() > 0));
            chk("model_in_ready", 32'(in_ready_o), 32'(m_rdy));
            chk("model_stall_cnt", 32'(stall_cnt_o), 32'(m_cnt));
            if (m_q.size() > 0)
                chk("model_out_data", 32'(out_data_o), 32'(m_q[0]));
            if (out_valid_o && out_ready_i)
                got.push_back(out_data_o);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d expected 0", 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] exp_out[7];
        int            exp_stall[5];
        exp_out = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA1, 8'hA2, 8'hD1};
`ifdef PIPE_STAGE_STALL_CNT_EN
        exp_stall = '{1, 2, 3, 3, 3};
`else
        exp_stall = '{0, 0, 0, 0, 0};
`endif

        // Reset state and INIT hold-off with in_valid_i held high.
        #12;
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_in_ready", 32'(in_ready_o), 32'd0);
        chk("rst_out_data", 32'(out_data_o), 32'h00);
        chk("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
        tick();
        rst_i      = 1'b0;
        in_valid_i = 1'b1;
        in_data_i  = 8'h11;
        @(negedge clk_i);
        chk("init_in_ready_c1", 32'(in_ready_o), 32'd0);
        chk("init_out_valid_c1", 32'(out_valid_o), 32'd0);
        @(negedge clk_i);
        chk("init_in_ready_c2", 32'(in_ready_o), 32'd1);
        chk("init_out_valid_c2", 32'(out_valid_o), 32'd0);

        // Streaming with out_ready_i high.
        tick();
        in_data_i = 8'h22;
        @(negedge clk_i);
        chk("stream_latency_valid", 32'(out_valid_o), 32'd1);
        chk("stream_latency_data", 32'(out_data_o), 32'h11);
        tick();
        in_data_i = 8'h33;
        tick();
        in_data_i = 8'h44;
        @(negedge clk_i);
        chk("stream_no_bubble", 32'(out_data_o), 32'h33);
        tick();
        in_valid_i = 1'b0;
        tick();
        tick();

        // Back-pressure fills the skid entry.
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 8'hA1;
        tick();
        in_data_i = 8'hA2;
        tick();
        in_valid_i = 1'b0;
        @(negedge clk_i);
        chk("skid_in_ready_low", 32'(in_ready_o), 32'd0);
        chk("skid_hold_a1", 32'(out_data_o), 32'hA1);
        tick();
        tick();
        @(negedge clk_i);
        chk("skid_still_a1", 32'(out_data_o), 32'hA1);
        tick();
        out_ready_i = 1'b1;
        tick();
        @(negedge clk_i);
        chk("skid_drain_a2", 32'(out_data_o), 32'hA2);
        chk("skid_ready_back", 32'(in_ready_o), 32'd1);
        tick();
        @(negedge clk_i);
        chk("skid_empty", 32'(out_valid_o), 32'd0);

        // Flush while FULL, with a concurrent offer that must be discarded.
        tick();
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 8'hB1;
        tick();
        in_data_i = 8'hB2;
        tick();
        in_data_i = 8'hB3;
        flush_i   = 1'b1;
        tick();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        chk("flush_out_valid", 32'(out_valid_o), 32'd0);
        chk("flush_in_ready", 32'(in_ready_o), 32'd1);
        chk("flush_data_cleared", 32'(out_data_o), 32'h00);
        tick();
        out_ready_i = 1'b1;
        tick();
        tick();

        // Asynchronous reset between edges while HALF.
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 8'hC1;
        tick();
        in_valid_i = 1'b0;
        @(negedge clk_i);
        chk("half_before_rst", 32'(out_data_o), 32'hC1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid_o), 32'd0);
        chk("async_rst_data", 32'(out_data_o), 32'h00);
        chk("async_rst_ready", 32'(in_ready_o), 32'd0);
        tick();
        rst_i = 1'b0;

        // Stall counter under sustained back-pressure.
        in_valid_i = 1'b1;
        in_data_i  = 8'hD1;
        tick();
        tick();
        in_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk_i);
            chk($sformatf("stall_cnt_%0d", i), 32'(stall_cnt_o), 32'(exp_stall[i]));
        end
        out_ready_i = 1'b1;
        tick();
        tick();
        tick();

        // Delivered payload order: flushed and reset-lost entries never appear.
        chk("delivered_count", 32'(got.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < got.size())
                chk($sformatf("delivered_%0d", i), 32'(got[i]), 32'(exp_out[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
